// File: rtl/seq_divider.sv
// seq_divider: restoring divider, 2*dw-bit dividend / dw-bit divisor -> 2*dw-bit quotient, dw-bit remainder.
// Latency: 2*dw+1 edges from acceptance (b!=0), 1 edge for b==0; one operation in flight at a time.
// Backpressure: in_ready only in IDLE; results held in DONE until out_ready. Pattern detect: SEQ_DIVIDER_PATTERN_DETECT_EN.
module seq_divider #(
  parameter int dw      = 8,
  parameter int PATTERN = 18
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*dw-1:0] c,
  input  logic [dw-1:0]   b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*dw-1:0] q,
  output logic [dw-1:0]   r,
  output logic            div_by_zero,
  output logic            pattern_detect
);

  localparam int CW = $clog2(2*dw);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  // dvd_q starts as the dividend and fills with quotient bits from the LSB as it shifts out
  logic [2*dw-1:0] dvd_q, dvd_d;
  logic [dw:0]     rem_q, rem_d;
  logic [dw-1:0]   div_q, div_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*dw-1:0] q_q, q_d;
  logic [dw-1:0]   r_q, r_d;
  logic            dbz_q, dbz_d;
  logic            ov_q, ov_d;

  logic [dw:0]     rem_sh, rem_new;
  logic            qbit;
  logic [2*dw-1:0] quo_next;
  logic            last_iter;

  // One restoring step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    rem_sh   = {rem_q[dw-1:0], dvd_q[2*dw-1]};
    qbit     = (rem_sh >= {1'b0, div_q});
    rem_new  = qbit ? (rem_sh - {1'b0, div_q}) : rem_sh;
    quo_next = {dvd_q[2*dw-2:0], qbit};
    last_iter = (state_q == BUSY) && (cnt_q == CW'(2*dw-1));
  end

  // Next-state and datapath load decisions
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvd_d = c;
          div_d = b;
          rem_d = '0;
          cnt_d = '0;
          if (b != '0) begin
            state_d = BUSY;
          end else begin
            state_d = DONE;
            q_d     = '1;
            r_d     = c[dw-1:0];
            dbz_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        rem_d = rem_new;
        dvd_d = quo_next;
        cnt_d = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = DONE;
          cnt_d   = '0;
          q_d     = quo_next;
          r_d     = rem_new[dw-1:0];
          dbz_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ov_d = (state_d == DONE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q <= '0;
      rem_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      q_q   <= '0;
      r_q   <= '0;
      dbz_q <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      dvd_q <= dvd_d;
      rem_q <= rem_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      r_q   <= r_d;
      dbz_q <= dbz_d;
      ov_q  <= ov_d;
    end
  end

`ifdef SEQ_DIVIDER_PATTERN_DETECT_EN
  localparam logic [2*dw-1:0] PAT_EXT = (2*dw)'(PATTERN[dw-1:0]);
  logic pd_q, pd_d;

  // Flag registered alongside q; divide-by-zero and new/finished operations clear it
  always_comb begin
    pd_d = pd_q;
    if (last_iter)                                  pd_d = (quo_next == PAT_EXT);
    else if ((state_q == IDLE) && in_valid)         pd_d = 1'b0;
    else if ((state_q == DONE) && out_ready)        pd_d = 1'b0;
  end

  // Pattern flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pd_q <= 1'b0;
    else        pd_q <= pd_d;
  end

  assign pattern_detect = pd_q;
`else
  assign pattern_detect = 1'b0;
`endif

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = ov_q;
  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider: the inverse of the team's pipelined dw x dw multiplier/pattern-detect datapath.
- Accepts a 2*dw-bit dividend (the multiplier's product width) and a dw-bit divisor.
- Produces the quotient and remainder after a fixed iteration count.
- Sits downstream of the multiplier path; used to recover operands and check products. Valid/ready handshake on both sides.

Parameters:
- dw, 8, divisor/remainder width; dividend and quotient are 2*dw bits.
- PATTERN, 18, quotient value flagged by the optional pattern detect; dw bits, zero-extended for the compare.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block idle, can accept
- c  input  2*dw  dividend
- b  input  dw  divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- q  output  2*dw  quotient
- r  output  dw  remainder
- div_by_zero  output  1  result came from b==0
- pattern_detect  output  1  quotient equals PATTERN (optional feature)

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset: state=IDLE, in_ready=1, out_valid=0, q=0, r=0, div_by_zero=0, pattern_detect=0, iteration counter=0.
- Reset asserted mid-operation aborts the operation; no result is ever emitted for it.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE), decoded from state. out_valid = (state==DONE), registered.
- IDLE:
  - Input handshake is in_valid && in_ready at a rising edge. It latches c and b and clears the partial remainder (dw+1 bits).
  - b!=0: go to BUSY with count=0.
  - b==0: go directly to DONE with q=all ones, r=c[dw-1:0], div_by_zero=1.
- BUSY, once per cycle, MSB first:
  - rem = {rem[dw-1:0], next dividend bit}.
  - If rem >= {1'b0,b}: rem = rem - b and the quotient bit is 1; otherwise the quotient bit is 0.
  - After 2*dw iterations go to DONE and load q/r; div_by_zero=0.
- Latency:
  - b!=0: out_valid is high after exactly 2*dw+1 rising edges counted from and including the accepting edge. For dw=8 that is the 17th edge.
  - b==0: out_valid is high after the accepting edge itself (latency 1).
- DONE:
  - q, r, div_by_zero and pattern_detect are held stable until out_valid && out_ready.
  - On that edge go to IDLE and clear out_valid. in_ready rises in the following cycle; there is no same-cycle turnaround.
- in_valid is ignored outside IDLE. c and b may change freely after acceptance.
- Width rules:
  - r < b always, so it fits in dw bits.
  - Quotient spans the full 2*dw range (c=0xFFFF, b=1 gives 0xFFFF).
  - c=0 gives q=0, r=0 after the full latency.
  - c < b gives q=0, r=c.

Optional Feature:
- Macro: SEQ_DIVIDER_PATTERN_DETECT_EN.
- Defined:
  - pattern_detect is registered together with q on entry to DONE, as (q == PATTERN).
  - It is forced 0 when div_by_zero=1.
  - It is held through DONE and cleared on the output handshake or by reset.
- Not defined: the compare logic is absent and pattern_detect is tied to 0. The port list is unchanged.

Test Plan:
- c=324, b=18, out_ready=1:
  - out_valid high 17 edges after acceptance; q=18, r=0.
  - pattern_detect=1 with the macro, 0 without.
- c=1000, b=7 -> q=142, r=6, div_by_zero=0, pattern_detect=0. Then c=0xFFFF, b=1 -> q=0xFFFF, r=0.
- c=0x1234, b=0 -> out_valid on the edge after acceptance; q=0xFFFF, r=0x34, div_by_zero=1, pattern_detect=0.
- Backpressure: c=5, b=9 with out_ready=0 for 5 cycles.
  - q=0, r=5 are held stable and in_ready stays 0.
  - A new in_valid pulse is ignored.
  - Raising out_ready gives one handshake, then in_ready=1 next cycle.
- Reset mid-op: rst_n low after iteration 7 of c=0xABCD, b=0x12.
  - Asynchronously: out_valid=0, in_ready=1, q=0, r=0.
  - After release, c=100, b=10 gives q=10, r=0 at the normal latency.
- Back-to-back: three operations with in_valid held high continuously. Each completes in order, with exactly one idle cycle between out handshake and next acceptance.
